// File: rtl/uni_arbiter_if.sv
// uni_if: generic valid/ready request channel shared by the IFU, the LSU and the
// memory-side bridge. The master drives the request fields and holds them until
// the cycle where valid & ready are both high; rdata is meaningful only in that cycle.
interface uni_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        reqtyp;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        size;
  logic [DATA_W-1:0] rdata;

  modport Master (
    output valid,
    output addr,
    output reqtyp,
    output wdata,
    output size,
    input  ready,
    input  rdata
  );

  modport Slave (
    input  valid,
    input  addr,
    input  reqtyp,
    input  wdata,
    input  size,
    output ready,
    output rdata
  );
endinterface

// File: rtl/uni_arbiter.sv
// uni_arbiter: shares one memory-side uni_if between the instruction fetch unit and
// the load/store unit. One requester is granted per transaction and the grant is held
// until the memory handshake completes. The LSU has priority; a small counter of
// back-to-back LSU grants taken while the IFU waits forces an IFU grant once it
// reaches LSU_BURST_MAX, so instruction fetch cannot starve.
// Every handshake is followed by one IDLE cycle in which the next winner is chosen.
module uni_arbiter #(
  // Consecutive LSU grants allowed while the IFU is pending (legal range 1..15).
  parameter int unsigned LSU_BURST_MAX = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  uni_if.Slave       UniIf_IFU,
  uni_if.Slave       UniIf_LSU,
  uni_if.Master      UniIf_M,
  output logic [1:0] o_grant
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GNT_IFU = 2'd1;
  localparam logic [1:0] ST_GNT_LSU = 2'd2;

  localparam logic [3:0] BURST_MAX  = 4'(LSU_BURST_MAX);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [3:0] lsu_cnt_q;
  logic [3:0] lsu_cnt_d;

  logic       ifu_req;
  logic       lsu_req;
  logic       ifu_forced;
  logic       lsu_wins;
  logic       m_valid;
  logic       m_ready;
  logic       m_hs;

  assign ifu_req    = UniIf_IFU.valid;
  assign lsu_req    = UniIf_LSU.valid;
  assign m_ready    = UniIf_M.ready;

  // The IFU is forced through only when it is waiting and the LSU burst budget is spent.
  assign ifu_forced = ifu_req && (lsu_cnt_q == BURST_MAX);
  assign lsu_wins   = lsu_req && !ifu_forced;

  // A memory transfer happens only when the forwarded valid meets memory ready.
  assign m_hs       = m_valid && m_ready;

  // Next-state and starvation-counter logic; arbitration happens only in IDLE.
  always_comb begin
    state_d   = state_q;
    lsu_cnt_d = lsu_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (lsu_wins) begin
          state_d = ST_GNT_LSU;
          // Count only LSU grants that actually kept a waiting IFU out.
          if (ifu_req) begin
            lsu_cnt_d = (lsu_cnt_q >= BURST_MAX) ? BURST_MAX : lsu_cnt_q + 4'd1;
          end else begin
            lsu_cnt_d = 4'd0;
          end
        end else if (ifu_req) begin
          state_d   = ST_GNT_IFU;
          lsu_cnt_d = 4'd0;
        end else begin
          lsu_cnt_d = 4'd0;
        end
      end
      ST_GNT_IFU: begin
        // A vanished request (protocol violation) also releases the grant.
        if (!ifu_req || m_hs) begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT_LSU: begin
        if (!lsu_req || m_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        lsu_cnt_d = 4'd0;
      end
    endcase
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      lsu_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      lsu_cnt_q <= lsu_cnt_d;
    end
  end

  // Request and ready steering: the granted side is wired straight through, all else is 0.
  always_comb begin
    m_valid         = 1'b0;
    UniIf_M.addr    = '0;
    UniIf_M.reqtyp  = '0;
    UniIf_M.wdata   = '0;
    UniIf_M.size    = '0;
    UniIf_IFU.ready = 1'b0;
    UniIf_LSU.ready = 1'b0;
    unique case (state_q)
      ST_GNT_IFU: begin
        m_valid         = UniIf_IFU.valid;
        UniIf_M.addr    = UniIf_IFU.addr;
        UniIf_M.reqtyp  = UniIf_IFU.reqtyp;
        UniIf_M.wdata   = UniIf_IFU.wdata;
        UniIf_M.size    = UniIf_IFU.size;
        UniIf_IFU.ready = m_ready;
      end
      ST_GNT_LSU: begin
        m_valid         = UniIf_LSU.valid;
        UniIf_M.addr    = UniIf_LSU.addr;
        UniIf_M.reqtyp  = UniIf_LSU.reqtyp;
        UniIf_M.wdata   = UniIf_LSU.wdata;
        UniIf_M.size    = UniIf_LSU.size;
        UniIf_LSU.ready = m_ready;
      end
      default: begin
        m_valid = 1'b0;
      end
    endcase
  end

  assign UniIf_M.valid = m_valid;

  // Read data is broadcast; only the requester seeing ready=1 consumes it.
  assign UniIf_IFU.rdata = UniIf_M.rdata;
  assign UniIf_LSU.rdata = UniIf_M.rdata;

  assign o_grant = {state_q == ST_GNT_LSU, state_q == ST_GNT_IFU};

`ifndef SYNTHESIS
  // A granted requester must hold valid until its handshake.
  a_ifu_valid_held : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == ST_GNT_IFU) |-> UniIf_IFU.valid)
    else $warning("uni_arbiter: IFU dropped valid while granted, grant released");

  a_lsu_valid_held : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == ST_GNT_LSU) |-> UniIf_LSU.valid)
    else $warning("uni_arbiter: LSU dropped valid while granted, grant released");

  // Both requester readies can never be high together.
  a_ready_exclusive : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(UniIf_IFU.ready && UniIf_LSU.ready));

  // The starvation counter never exceeds its limit.
  a_cnt_bounded : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    lsu_cnt_q <= BURST_MAX);
`endif

endmodule

// File: tb/tb_uni_arbiter.sv
// Directed bench for uni_arbiter: the bench plays IFU, LSU and memory. Inputs change on
// the falling clock edge and outputs are sampled 1 ns later, away from the rising edge.
module tb_uni_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] grant;

  int n_checks;
  int n_errors;

  uni_if ifu_if ();
  uni_if lsu_if ();
  uni_if mem_if ();

  uni_arbiter #(.LSU_BURST_MAX(4)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .UniIf_IFU(ifu_if),
    .UniIf_LSU(lsu_if),
    .UniIf_M  (mem_if),
    .o_grant  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected grant per cycle with both requesters always valid and zero-wait memory:
  // four LSU grants, one IFU grant, then the LSU again, each followed by an IDLE cycle.
  logic [1:0] exp_g [14];
  int hs;

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_g = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00,
              2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b10};

    rst_n         = 1'b0;
    ifu_if.valid  = 1'b0; ifu_if.addr = '0; ifu_if.reqtyp = '0; ifu_if.wdata = '0; ifu_if.size = '0;
    lsu_if.valid  = 1'b0; lsu_if.addr = '0; lsu_if.reqtyp = '0; lsu_if.wdata = '0; lsu_if.size = '0;
    mem_if.ready  = 1'b0; mem_if.rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mvalid", 64'(mem_if.valid), 64'd0);
    chk("rst_ifu_ready", 64'(ifu_if.ready), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_if.ready), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: IFU read, memory ready on the third granted cycle
    @(negedge clk);
    ifu_if.valid = 1'b1; ifu_if.addr = 32'h8000_0000; ifu_if.reqtyp = 2'd0; ifu_if.size = 2'd2;
    #1;
    chk("t1_idle_grant", 64'(grant), 64'd0);
    chk("t1_idle_mvalid", 64'(mem_if.valid), 64'd0);
    @(negedge clk); #1;
    chk("t1_grant", 64'(grant), 64'h1);
    chk("t1_mvalid", 64'(mem_if.valid), 64'd1);
    chk("t1_maddr", 64'(mem_if.addr), 64'h8000_0000);
    chk("t1_msize", 64'(mem_if.size), 64'd2);
    chk("t1_ready_wait1", 64'(ifu_if.ready), 64'd0);
    @(negedge clk); #1;
    chk("t1_ready_wait2", 64'(ifu_if.ready), 64'd0);
    @(negedge clk);
    mem_if.ready = 1'b1; mem_if.rdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_ifu_ready", 64'(ifu_if.ready), 64'd1);
    chk("t1_ifu_rdata", 64'(ifu_if.rdata), 64'hDEAD_BEEF);
    chk("t1_lsu_ready", 64'(lsu_if.ready), 64'd0);
    @(negedge clk);
    ifu_if.valid = 1'b0; mem_if.ready = 1'b0;
    #1;
    chk("t1_back_idle", 64'(grant), 64'd0);
    chk("t1_idle_maddr", 64'(mem_if.addr), 64'd0);

    // Test 2: simultaneous requests, LSU store wins, IFU follows after one IDLE cycle
    @(negedge clk);
    ifu_if.valid = 1'b1; ifu_if.addr = 32'h8000_0100; ifu_if.reqtyp = 2'd0;
    lsu_if.valid = 1'b1; lsu_if.addr = 32'h8000_1000; lsu_if.reqtyp = 2'd1;
    lsu_if.wdata = 32'h1234_5678; lsu_if.size = 2'd2;
    @(negedge clk); #1;
    chk("t2_lsu_grant", 64'(grant), 64'h2);
    chk("t2_maddr", 64'(mem_if.addr), 64'h8000_1000);
    chk("t2_mreqtyp", 64'(mem_if.reqtyp), 64'd1);
    chk("t2_mwdata", 64'(mem_if.wdata), 64'h1234_5678);
    mem_if.ready = 1'b1;
    #1;
    chk("t2_lsu_ready", 64'(lsu_if.ready), 64'd1);
    chk("t2_ifu_ready", 64'(ifu_if.ready), 64'd0);
    @(negedge clk);
    lsu_if.valid = 1'b0; mem_if.ready = 1'b0;
    #1;
    chk("t2_bubble", 64'(grant), 64'd0);
    @(negedge clk); #1;
    chk("t2_ifu_grant", 64'(grant), 64'h1);
    chk("t2_ifu_maddr", 64'(mem_if.addr), 64'h8000_0100);
    mem_if.ready = 1'b1;
    #1;
    chk("t2_ifu_ready", 64'(ifu_if.ready), 64'd1);
    @(negedge clk);
    ifu_if.valid = 1'b0; mem_if.ready = 1'b0;
    @(negedge clk);

    // Tests 3/4: both requesters always valid, zero-wait memory
    ifu_if.addr = 32'h8000_0200;
    lsu_if.addr = 32'h8000_2000; lsu_if.reqtyp = 2'd0;
    ifu_if.valid = 1'b1; lsu_if.valid = 1'b1;
    mem_if.ready = 1'b1; mem_if.rdata = 32'h0BAD_F00D;
    hs = 0;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("t3_grant_%0d", i), 64'(grant), 64'(exp_g[i]));
      chk($sformatf("t3_ifu_ready_%0d", i), 64'(ifu_if.ready), 64'(exp_g[i] == 2'b01));
      chk($sformatf("t3_lsu_ready_%0d", i), 64'(lsu_if.ready), 64'(exp_g[i] == 2'b10));
      if (mem_if.valid && mem_if.ready) hs++;
    end
    chk("t3_handshakes", 64'(hs), 64'd7);
    @(negedge clk);
    ifu_if.valid = 1'b0; lsu_if.valid = 1'b0; mem_if.ready = 1'b0;
    @(negedge clk);

    // Test 5: asynchronous reset during an LSU grant with memory stalled
    ifu_if.valid = 1'b1; lsu_if.valid = 1'b1; lsu_if.addr = 32'h8000_3000;
    @(negedge clk); #1;
    chk("t5_lsu_grant", 64'(grant), 64'h2);
    chk("t5_mvalid", 64'(mem_if.valid), 64'd1);
    #2;
    rst_n = 1'b0;
    ifu_if.valid = 1'b0; lsu_if.valid = 1'b0;
    #1;
    chk("t5_rst_mvalid", 64'(mem_if.valid), 64'd0);
    chk("t5_rst_grant", 64'(grant), 64'd0);
    chk("t5_rst_maddr", 64'(mem_if.addr), 64'd0);
    chk("t5_rst_lsu_ready", 64'(lsu_if.ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t5_post_grant", 64'(grant), 64'd0);
    chk("t5_post_cnt", 64'(dut.lsu_cnt_q), 64'd0);

    // Test 6: granted IFU withdraws its request before memory ready
    @(negedge clk);
    ifu_if.valid = 1'b1; ifu_if.addr = 32'h8000_0300;
    @(negedge clk); #1;
    chk("t6_grant", 64'(grant), 64'h1);
    chk("t6_mvalid", 64'(mem_if.valid), 64'd1);
    @(negedge clk);
    ifu_if.valid = 1'b0; mem_if.ready = 1'b1;
    #1;
    chk("t6_mvalid_drop", 64'(mem_if.valid), 64'd0);
    chk("t6_no_hs", 64'(mem_if.valid && mem_if.ready), 64'd0);
    @(negedge clk);
    mem_if.ready = 1'b0;
    #1;
    chk("t6_idle", 64'(grant), 64'd0);
    @(negedge clk); #1;
    chk("t6_stay_idle", 64'(grant), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
